// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between NREQ requesters. A round-robin
//   arbiter accepts one operation per grant (valid/ready), registers the
//   operands toward the ALU, captures the result one cycle later and returns
//   it to the owning requester with a one-cycle rsp_valid strobe.
//
//   Build option: define ALU_SHARE_ARB_FIXED_PRIO_EN for fixed priority
//   (lowest index wins, no rotating pointer). Default is round-robin.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   req_valid[NREQ]   per-requester operation request
//   req_ready[NREQ]   per-requester accept strobe (one-hot or zero)
//   req_a/req_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op            packed ALU control, requester i at [i*OPW +: OPW]
//   rsp_valid[NREQ]   one-cycle result strobe to the owning requester
//   rsp_data          shared result bus, qualified by rsp_valid
//   alu_a/alu_b/alu_control  registered operands to the shared ALU
//   alu_o             combinational ALU result
//   busy              high while an operation is in flight (EXEC)
module alu_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 6,
    parameter int OPW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*OPW-1:0]   req_op,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [OPW-1:0]        alu_control,
    input  logic [WIDTH-1:0]      alu_o,
    output logic                  busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   gidx;
    logic            gvalid;
    logic [NREQ-1:0] ready_c;
    logic            transfer;

`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
    logic [IW-1:0]   rr_ptr;
    int unsigned     idx;
`endif

    // Winner selection; only meaningful outside EXEC, gated below.
    always_comb begin
        gvalid = 1'b0;
        gidx   = '0;
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!gvalid && req_valid[i]) begin
                gvalid = 1'b1;
                gidx   = IW'(i);
            end
        end
`else
        idx = 0;
        // Scan rr_ptr+1 .. rr_ptr+NREQ so the last owner is considered last.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!gvalid && req_valid[idx]) begin
                gvalid = 1'b1;
                gidx   = IW'(idx);
            end
        end
`endif
    end

    always_comb begin
        ready_c = '0;
        if (rst_n && (state != EXEC) && gvalid) begin
            ready_c[gidx] = 1'b1;
        end
    end

    assign req_ready = ready_c;
    assign transfer  = |(req_valid & ready_c);
    assign busy      = (state == EXEC);

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (transfer) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    state_nx = transfer ? EXEC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            rsp_data    <= '0;
            owner       <= '0;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
            rr_ptr      <= IW'(NREQ - 1);
`endif
        end else begin
            if (transfer) begin
                alu_a       <= req_a[gidx*WIDTH +: WIDTH];
                alu_b       <= req_b[gidx*WIDTH +: WIDTH];
                alu_control <= req_op[gidx*OPW +: OPW];
                owner       <= gidx;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
                rr_ptr      <= gidx;
`endif
            end
            if (state == EXEC) begin
                rsp_data <= alu_o;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed, table-driven bench for alu_share_arbiter (NREQ=4, WIDTH=6,
//   OPW=2) with a stub ALU o = (a + b + control) mod 64. Each table row is
//   one clock cycle of inputs plus the outputs expected in that cycle.
module tb_alu_share_arbiter;

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [23:0] req_a;
    logic [23:0] req_b;
    logic [7:0]  req_op;
    logic [3:0]  rsp_valid;
    logic [5:0]  rsp_data;
    logic [5:0]  alu_a;
    logic [5:0]  alu_b;
    logic [1:0]  alu_control;
    logic [5:0]  alu_o;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.NREQ(4), .WIDTH(6), .OPW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_o(alu_o), .busy(busy)
    );

    assign alu_o = alu_a + alu_b + 6'(alu_control);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [23:0] a;
        logic [23:0] b;
        logic [7:0]  op;
        logic [3:0]  rdy;
        logic [3:0]  rsp;
        logic        bz;
        logic [5:0]  data;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [23:0] pk6(input int v0, input int v1, input int v2, input int v3);
        return {v3[5:0], v2[5:0], v1[5:0], v0[5:0]};
    endfunction

    function automatic logic [7:0] pk2(input int v0, input int v1, input int v2, input int v3);
        return {v3[1:0], v2[1:0], v1[1:0], v0[1:0]};
    endfunction

    task automatic add(input logic r, input logic [3:0] v, input logic [23:0] a,
                       input logic [23:0] b, input logic [7:0] o, input logic [3:0] rdy,
                       input logic [3:0] rsp, input logic bz, input logic [5:0] d);
        vec_t t;
        t.rst = r; t.rv = v; t.a = a; t.b = b; t.op = o;
        t.rdy = rdy; t.rsp = rsp; t.bz = bz; t.data = d;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    logic [23:0] a5, b2, z6;
    logic [7:0]  o1, z2;
    int          got[4];
    int          ngr;

    initial begin
        a5 = pk6(5, 5, 5, 5);
        b2 = pk6(2, 2, 2, 2);
        o1 = pk2(1, 1, 1, 1);
        z6 = '0;
        z2 = '0;

        // Reset with everyone valid, then contention among 0,1,3 (5+2+1=8).
        add(0, 4'b1111, a5, b2, o1, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b1111, a5, b2, o1, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b1111, a5, b2, o1, 4'b0000, 4'b0000, 0, 0);
        add(1, 4'b1011, a5, b2, o1, 4'b0001, 4'b0000, 0, 0);
        add(1, 4'b1011, a5, b2, o1, 4'b0000, 4'b0000, 1, 0);
        add(1, 4'b1011, a5, b2, o1, FIXED ? 4'b0001 : 4'b0010, 4'b0001, 0, 8);
        add(1, 4'b1011, a5, b2, o1, 4'b0000, 4'b0000, 1, 8);
        add(1, 4'b1011, a5, b2, o1, FIXED ? 4'b0001 : 4'b1000,
            FIXED ? 4'b0001 : 4'b0010, 0, 8);
        add(1, 4'b1011, a5, b2, o1, 4'b0000, 4'b0000, 1, 8);
        add(1, 4'b1011, a5, b2, o1, 4'b0001, FIXED ? 4'b0001 : 4'b1000, 0, 8);
        add(1, 4'b0000, a5, b2, o1, 4'b0000, 4'b0000, 1, 8);
        add(1, 4'b0000, a5, b2, o1, 4'b0000, 4'b0001, 0, 8);
        add(1, 4'b0000, a5, b2, o1, 4'b0000, 4'b0000, 0, 8);
        // Single op from requester 2: 9+4+0 = 13; others carry junk operands.
        add(1, 4'b0100, pk6(63, 63, 9, 63), pk6(63, 63, 4, 63), pk2(3, 3, 0, 3),
            4'b0100, 4'b0000, 0, 8);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0000, 1, 8);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0100, 0, 13);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0000, 0, 13);
        // Back-to-back from requester 1: 10+20+2 = 32, then 30+40+3 = 73 -> 9.
        add(1, 4'b0010, pk6(0, 10, 0, 0), pk6(0, 20, 0, 0), pk2(0, 2, 0, 0),
            4'b0010, 4'b0000, 0, 13);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0000, 1, 13);
        add(1, 4'b0010, pk6(0, 30, 0, 0), pk6(0, 40, 0, 0), pk2(0, 3, 0, 0),
            4'b0010, 4'b0010, 0, 32);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0000, 1, 32);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0010, 0, 9);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0000, 0, 9);
        // Reset during EXEC: op abandoned, no response, everything cleared.
        add(1, 4'b0001, pk6(1, 0, 0, 0), pk6(1, 0, 0, 0), z2, 4'b0001, 4'b0000, 0, 9);
        add(0, 4'b0000, z6, z6, z2, 4'b0000, 4'b0000, 1, 9);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0000, 0, 0);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0000, 0, 0);
        // Pointer back at 3: requester 0 beats 3 (2+3+1 = 6), then 3 (63+63+3 -> 1).
        add(1, 4'b1001, pk6(2, 0, 0, 63), pk6(3, 0, 0, 63), pk2(1, 0, 0, 3),
            4'b0001, 4'b0000, 0, 0);
        add(1, 4'b1000, pk6(2, 0, 0, 63), pk6(3, 0, 0, 63), pk2(1, 0, 0, 3),
            4'b0000, 4'b0000, 1, 0);
        add(1, 4'b1000, pk6(2, 0, 0, 63), pk6(3, 0, 0, 63), pk2(1, 0, 0, 3),
            4'b1000, 4'b0001, 0, 6);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0000, 1, 6);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b1000, 0, 1);
        add(1, 4'b0000, z6, z6, z2, 4'b0000, 4'b0000, 0, 1);

        foreach (tbl[i]) begin
            rst_n     = tbl[i].rst;
            req_valid = tbl[i].rv;
            req_a     = tbl[i].a;
            req_b     = tbl[i].b;
            req_op    = tbl[i].op;
            @(negedge clk);
            chk($sformatf("r%0d_req_ready", i), int'(req_ready), int'(tbl[i].rdy));
            chk($sformatf("r%0d_rsp_valid", i), int'(rsp_valid), int'(tbl[i].rsp));
            chk($sformatf("r%0d_busy", i), int'(busy), int'(tbl[i].bz));
            chk($sformatf("r%0d_rsp_data", i), int'(rsp_data), int'(tbl[i].data));
            @(posedge clk);
            #1;
        end

        // Requesters 0 and 3 both always valid: record the first four grants.
        req_valid = 4'b1001;
        req_a     = pk6(1, 0, 0, 2);
        req_b     = pk6(1, 0, 0, 2);
        req_op    = z2;
        ngr       = 0;
        for (int c = 0; c < 20 && ngr < 4; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                got[ngr] = (req_ready == 4'b0001) ? 0 : (req_ready == 4'b1000) ? 3 : 9;
                ngr++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 4'b0000;
        chk("prio_grant_count", ngr, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("prio_grant%0d", i), got[i], FIXED ? 0 : ((i % 2) != 0 ? 3 : 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
